l1_mem_burst_ctrl: RTL and testbench
====================================

# l1_mem_burst_ctrl

Burst transfer engine between the L1 data cache and the system-side data memory. Each accepted line request is converted into one burst command plus data beats on the memory side: a READ_BURST_LEN-beat refill or a WRITE_BURST_LEN-beat write-back. Refill beats are returned to the cache tagged with their word index. The block sits directly downstream of the L1 miss/evict logic in the sys_clk domain.

## Interface
- DATA_WIDTH, 32, beat/word width in bits
- DATA_ADDR_WIDTH, 32, byte address width
- READ_BURST_LEN, 8, refill beats per line (power of 2, ≥2)
- WRITE_BURST_LEN, 8, write-back beats per line (power of 2, ≥2)

Ports:
- sys_clk  in  1  single clock; everything is rising-edge.
- sys_rst  in  1  synchronous, active-high reset.
- cache_req_valid  in  1  cache presents a line request.
- cache_req_ready  out  1  request accepted when valid&ready.
- cache_req_write  in  1  1 = write-back, 0 = refill.
- cache_req_addr  in  DATA_ADDR_WIDTH  byte address of the requested word.
- cache_wdata  in  DATA_WIDTH  write-back beat from the cache.
- cache_wdata_valid  in  1  write-back beat valid.
- cache_wdata_ready  out  1  write-back beat consumed.
- cache_rdata  out  DATA_WIDTH  refill beat.
- cache_rdata_valid  out  1  refill beat valid; no backpressure.
- cache_rdata_idx  out  clog2(READ_BURST_LEN)  word index of the beat within the line.
- cache_rdata_last  out  1  final refill beat.
- cache_done  out  1  one-cycle pulse when the transaction completes.
- mem_cmd_valid  out  1  burst command valid.
- mem_cmd_ready  in  1  memory accepts the command.
- mem_cmd_write  out  1  burst direction.
- mem_cmd_addr  out  DATA_ADDR_WIDTH  burst start byte address.
- mem_wdata  out  DATA_WIDTH  write beat to memory.
- mem_wdata_valid  out  1  write beat valid.
- mem_wdata_ready  in  1  memory accepts the write beat.
- mem_rdata  in  DATA_WIDTH  read beat from memory.
- mem_rdata_valid  in  1  read beat valid; must be accepted every cycle.

## Operation
- FSM states: IDLE → CMD → (RD_DATA | WR_DATA) → DONE → IDLE.
- IDLE: cache_req_ready=1. On a handshake, latch write and addr, clear the beat counter, and go to CMD.
- CMD: mem_cmd_valid=1, with mem_cmd_write and mem_cmd_addr held stable. When mem_cmd_ready=1, go to RD_DATA if the request was a refill, otherwise WR_DATA.
- Line base address = addr with the low clog2(LEN)+2 bits cleared. The start word index (s) is 0, except as set by CRITICAL_WORD_FIRST_EN for refills.
- RD_DATA:
  - Each mem_rdata_valid cycle registers the beat.
  - The beat appears on the next cycle on cache_rdata/cache_rdata_valid, with idx = (s + count) mod READ_BURST_LEN.
  - cache_rdata_last is asserted on beat READ_BURST_LEN−1.
  - After the last beat is captured, go to DONE.
- WR_DATA:
  - mem_wdata = cache_wdata and mem_wdata_valid = cache_wdata_valid (combinational).
  - cache_wdata_ready = mem_wdata_ready.
  - The counter advances on each handshake. After handshake WRITE_BURST_LEN−1, go to DONE.
  - Beats are always sent in line order from word 0.
- DONE: cache_done=1 for one cycle, then go to IDLE. cache_req_ready is 0 in DONE.
- mem_rdata_valid outside RD_DATA is ignored. cache_wdata_valid outside WR_DATA is not acknowledged.
- Beat counter: clog2(max(READ_BURST_LEN, WRITE_BURST_LEN))+1 bits, no wrap within a burst. Index arithmetic wraps modulo the burst length.

## Timing
- Reset values: cache_req_ready=0 during reset and 1 from the first cycle after. All other outputs are 0. State is IDLE and the counter is 0.
- sys_rst mid-transaction: return to IDLE immediately and drop in-flight beats. No cache_done is issued.
- Request accepted at cycle t: mem_cmd_valid rises at t+1.
- Command accepted at cycle c: read beats may arrive from c+1. Each beat is visible to the cache one cycle after its arrival.
- Minimum refill with zero memory wait: the handshake at t is followed by cache_done at t+READ_BURST_LEN+3.
- Write beats pass through with zero latency.
- Back-to-back transactions: the next request can be accepted in the cycle after DONE.

## Configuration
- CRITICAL_WORD_FIRST_EN defined:
  - A refill issues mem_cmd_addr = word-aligned addr, with s = addr[clog2(READ_BURST_LEN)+1:2].
  - Memory returns beats in wrapping order, so the requested word arrives first.
- CRITICAL_WORD_FIRST_EN undefined:
  - mem_cmd_addr = line base and s = 0 for every burst.
- Write-backs are identical with or without the macro.

## Test plan
- Reset: assert sys_rst for 2 cycles mid-refill → all outputs 0 and no cache_done. After release, cache_req_ready=1.
- Refill, addr 0x40, no wait, memory returns 0xA0..0xA7 → mem_cmd_addr=0x40. Beats appear with idx 0..7 and last on 0xA7, and cache_done follows one cycle after the last beat.
- Refill, addr 0x4C, with CRITICAL_WORD_FIRST_EN:
  - Expect mem_cmd_addr=0x4C and idx sequence 3,4,5,6,7,0,1,2.
  - Without the macro, expect mem_cmd_addr=0x40 and idx sequence 0..7.
- Write-back, addr 0x80, data 0x10..0x17:
  - mem_wdata_ready toggles 1,0 each cycle; mem_cmd_ready is delayed 3 cycles.
  - Expect 8 memory beats in order, with cache_wdata_ready mirroring mem_wdata_ready, and exactly one cache_done.
- Spurious mem_rdata_valid in IDLE or WR_DATA → no cache_rdata_valid and no state change.
- A refill followed immediately by a write-back request (held valid) is accepted in the cycle after DONE. Both complete with exactly two cache_done pulses.

Source files
------------

// File: rtl/l1_mem_burst_ctrl_if.sv
// Signal bundle for l1_mem_burst_ctrl: cache request/data channels on one side,
// memory burst command/data channels on the other.
// slave  : seen by the burst controller.
// master : seen by the surrounding cache and memory (or a testbench).
interface l1_mem_burst_ctrl_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int READ_BURST_LEN  = 8
);
    localparam int RIDX_W = $clog2(READ_BURST_LEN);

    // cache side
    logic                       cache_req_valid;
    logic                       cache_req_ready;
    logic                       cache_req_write;
    logic [DATA_ADDR_WIDTH-1:0] cache_req_addr;
    logic [DATA_WIDTH-1:0]      cache_wdata;
    logic                       cache_wdata_valid;
    logic                       cache_wdata_ready;
    logic [DATA_WIDTH-1:0]      cache_rdata;
    logic                       cache_rdata_valid;
    logic [RIDX_W-1:0]          cache_rdata_idx;
    logic                       cache_rdata_last;
    logic                       cache_done;

    // memory side
    logic                       mem_cmd_valid;
    logic                       mem_cmd_ready;
    logic                       mem_cmd_write;
    logic [DATA_ADDR_WIDTH-1:0] mem_cmd_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       mem_wdata_valid;
    logic                       mem_wdata_ready;
    logic [DATA_WIDTH-1:0]      mem_rdata;
    logic                       mem_rdata_valid;

    modport slave (
        input  cache_req_valid, cache_req_write, cache_req_addr,
        input  cache_wdata, cache_wdata_valid,
        output cache_req_ready, cache_wdata_ready,
        output cache_rdata, cache_rdata_valid, cache_rdata_idx, cache_rdata_last,
        output cache_done,
        output mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
        output mem_wdata, mem_wdata_valid,
        input  mem_cmd_ready, mem_wdata_ready, mem_rdata, mem_rdata_valid
    );

    modport master (
        output cache_req_valid, cache_req_write, cache_req_addr,
        output cache_wdata, cache_wdata_valid,
        input  cache_req_ready, cache_wdata_ready,
        input  cache_rdata, cache_rdata_valid, cache_rdata_idx, cache_rdata_last,
        input  cache_done,
        input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
        input  mem_wdata, mem_wdata_valid,
        output mem_cmd_ready, mem_wdata_ready, mem_rdata, mem_rdata_valid
    );
endinterface

// File: rtl/l1_mem_burst_ctrl.sv
// l1_mem_burst_ctrl: turns L1 line requests into one memory burst command plus
// data beats. Refills come back registered and tagged with their word index;
// write-back beats pass straight through.
// Optional feature: define CRITICAL_WORD_FIRST_EN to start refills at the
// requested word (wrapping burst) instead of at the line base.
module l1_mem_burst_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int READ_BURST_LEN  = 8,
    parameter int WRITE_BURST_LEN = 8
) (
    input logic                sys_clk,
    input logic                sys_rst,
    l1_mem_burst_ctrl_if.slave bus
);
    localparam int RIDX_W  = $clog2(READ_BURST_LEN);
    localparam int WIDX_W  = $clog2(WRITE_BURST_LEN);
    localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    // Masks that clear the in-line offset (word index plus byte offset).
    localparam logic [DATA_ADDR_WIDTH-1:0] RD_LINE_MASK = {DATA_ADDR_WIDTH{1'b1}} << (RIDX_W + 2);
    localparam logic [DATA_ADDR_WIDTH-1:0] WR_LINE_MASK = {DATA_ADDR_WIDTH{1'b1}} << (WIDX_W + 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic                       write_q, write_d;
    logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    // Registered refill beat presented to the cache.
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       rdata_valid_q, rdata_valid_d;
    logic [RIDX_W-1:0]          rdata_idx_q, rdata_idx_d;
    logic                       rdata_last_q, rdata_last_d;

    // Combinational outputs.
    logic                       req_ready;
    logic                       cmd_valid;
    logic                       cmd_write;
    logic [DATA_ADDR_WIDTH-1:0] cmd_addr_out;
    logic [DATA_WIDTH-1:0]      wdata_out;
    logic                       wdata_valid_out;
    logic                       wdata_ready_out;
    logic                       done;

    // Burst start address and first word index of the latched request.
    logic [DATA_ADDR_WIDTH-1:0] burst_addr;
    logic [RIDX_W-1:0]          start_idx;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [DATA_ADDR_WIDTH-1:0] WORD_MASK = {DATA_ADDR_WIDTH{1'b1}} << 2;

    // Refills start at the requested word; write-backs always start at word 0.
    assign burst_addr = write_q ? (addr_q & WR_LINE_MASK) : (addr_q & WORD_MASK);
    assign start_idx  = write_q ? '0 : addr_q[RIDX_W+1:2];
`else
    assign burst_addr = addr_q & (write_q ? WR_LINE_MASK : RD_LINE_MASK);
    assign start_idx  = '0;
`endif

    // Next-state logic and output decode for the burst FSM.
    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        rdata_d         = rdata_q;
        rdata_valid_d   = 1'b0;
        rdata_idx_d     = rdata_idx_q;
        rdata_last_d    = 1'b0;
        req_ready       = 1'b0;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_addr_out    = '0;
        wdata_out       = '0;
        wdata_valid_out = 1'b0;
        wdata_ready_out = 1'b0;
        done            = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.cache_req_valid) begin
                    write_d = bus.cache_req_write;
                    addr_d  = bus.cache_req_addr;
                    cnt_d   = '0;
                    state_d = CMD;
                end
            end

            CMD: begin
                cmd_valid    = 1'b1;
                cmd_write    = write_q;
                cmd_addr_out = burst_addr;
                if (bus.mem_cmd_ready) begin
                    state_d = write_q ? WR_DATA : RD_DATA;
                end
            end

            RD_DATA: begin
                // Beats beyond the burst length are dropped; the counter never wraps.
                if (bus.mem_rdata_valid && (cnt_q < CNT_W'(READ_BURST_LEN))) begin
                    rdata_d       = bus.mem_rdata;
                    rdata_valid_d = 1'b1;
                    rdata_idx_d   = start_idx + cnt_q[RIDX_W-1:0];
                    rdata_last_d  = (cnt_q == CNT_W'(READ_BURST_LEN - 1));
                    cnt_d         = cnt_q + CNT_W'(1);
                end
                // Leave once the last beat has been shown to the cache.
                if (rdata_valid_q && rdata_last_q) begin
                    state_d = DONE;
                end
            end

            WR_DATA: begin
                wdata_out       = bus.cache_wdata;
                wdata_valid_out = bus.cache_wdata_valid;
                wdata_ready_out = bus.mem_wdata_ready;
                if (bus.cache_wdata_valid && bus.mem_wdata_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WRITE_BURST_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Outputs are held low for the whole reset, not only after its first edge.
        if (sys_rst) begin
            req_ready       = 1'b0;
            cmd_valid       = 1'b0;
            cmd_write       = 1'b0;
            cmd_addr_out    = '0;
            wdata_out       = '0;
            wdata_valid_out = 1'b0;
            wdata_ready_out = 1'b0;
            done            = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_idx_q   <= '0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_idx_q   <= rdata_idx_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    assign bus.cache_req_ready   = req_ready;
    assign bus.cache_wdata_ready = wdata_ready_out;
    assign bus.cache_rdata       = rdata_q;
    assign bus.cache_rdata_valid = rdata_valid_q;
    assign bus.cache_rdata_idx   = rdata_idx_q;
    assign bus.cache_rdata_last  = rdata_last_q;
    assign bus.cache_done        = done;
    assign bus.mem_cmd_valid     = cmd_valid;
    assign bus.mem_cmd_write     = cmd_write;
    assign bus.mem_cmd_addr      = cmd_addr_out;
    assign bus.mem_wdata         = wdata_out;
    assign bus.mem_wdata_valid   = wdata_valid_out;
endmodule

// File: tb/tb_l1_mem_burst_ctrl.sv
// Directed testbench for l1_mem_burst_ctrl. Expected values are written out by
// hand per scenario; CRITICAL_WORD_FIRST_EN selects the refill expectations.
module tb_l1_mem_burst_ctrl;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int RLEN   = 8;
    localparam int WLEN   = 8;
    localparam int OUTS_W = 107;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    l1_mem_burst_ctrl_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .READ_BURST_LEN(RLEN)) bus ();

    l1_mem_burst_ctrl #(
        .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW),
        .READ_BURST_LEN(RLEN), .WRITE_BURST_LEN(WLEN)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Count completion pulses mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (bus.cache_done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [OUTS_W-1:0] all_outs();
        return {bus.cache_req_ready, bus.cache_wdata_ready, bus.cache_rdata,
                bus.cache_rdata_valid, bus.cache_rdata_idx, bus.cache_rdata_last,
                bus.cache_done, bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr,
                bus.mem_wdata, bus.mem_wdata_valid};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cache_req_valid   = 1'b0;
        bus.cache_req_write   = 1'b0;
        bus.cache_req_addr    = '0;
        bus.cache_wdata       = '0;
        bus.cache_wdata_valid = 1'b0;
        bus.mem_cmd_ready     = 1'b0;
        bus.mem_wdata_ready   = 1'b0;
        bus.mem_rdata         = '0;
        bus.mem_rdata_valid   = 1'b0;
    endtask

    // Present a request in an IDLE cycle and pass the handshake edge.
    task automatic start_request(input logic wr, input logic [AW-1:0] addr, input logic hold);
        bus.cache_req_valid = 1'b1;
        bus.cache_req_write = wr;
        bus.cache_req_addr  = addr;
        #1;
        checks++;
        if (bus.cache_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle got=%b exp=1", bus.cache_req_ready);
        end
        tick();
        if (!hold) bus.cache_req_valid = 1'b0;
    endtask

    // CMD phase: mem_cmd_ready held low for 'delay' cycles, then accepted.
    task automatic cmd_phase(input logic wr, input logic [AW-1:0] exp_addr, input int delay);
        for (int d = 0; d <= delay; d++) begin
            bus.mem_cmd_ready = (d == delay);
            #1;
            checks++;
            if ({bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr} !== {1'b1, wr, exp_addr}) begin
                errors++;
                $display("FAIL cmd_phase cyc %0d got=%b/%b/%h exp=1/%b/%h", d,
                         bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_addr, wr, exp_addr);
            end
            tick();
        end
        bus.mem_cmd_ready = 1'b0;
    endtask

    // Refill data phase with zero memory wait. Returns in the IDLE cycle after DONE.
    task automatic refill_data(input logic [DW-1:0] base, input int s);
        logic [DW+6:0] got, exp;
        logic          vis;
        int            k;
        for (int j = 0; j <= 10; j++) begin
            bus.mem_rdata_valid = (j < RLEN);
            bus.mem_rdata       = base + DW'(j);
            #1;
            vis = (j >= 1) && (j <= RLEN);
            k   = j - 1;
            exp = {vis, (j == RLEN + 1), (j == RLEN + 2),
                   vis ? base + DW'(k) : '0,
                   vis ? 3'((s + k) % RLEN) : 3'd0,
                   vis && (k == RLEN - 1)};
            got = {bus.cache_rdata_valid, bus.cache_done, bus.cache_req_ready,
                   vis ? bus.cache_rdata : '0,
                   vis ? bus.cache_rdata_idx : 3'd0,
                   vis ? bus.cache_rdata_last : 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL refill_beat cyc %0d got v/done/rdy/data/idx/last=%h exp=%h", j, got, exp);
            end
            if (j < 10) tick();
        end
        bus.mem_rdata_valid = 1'b0;
    endtask

    // Write-back data phase; spurious mem_rdata_valid is held high throughout.
    task automatic wb_data(input logic [DW-1:0] base, input logic toggle);
        int k   = 0;
        int cyc = 0;
        logic [DW+3:0] got, exp;
        while (k < WLEN && cyc < 40) begin
            bus.cache_wdata_valid = 1'b1;
            bus.cache_wdata       = base + DW'(k);
            bus.mem_wdata_ready   = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.mem_rdata_valid   = 1'b1;
            bus.mem_rdata         = 32'hDEAD_BEEF;
            #1;
            exp = {1'b1, base + DW'(k), bus.mem_wdata_ready, 2'b00};
            got = {bus.mem_wdata_valid, bus.mem_wdata, bus.cache_wdata_ready,
                   bus.cache_rdata_valid, bus.cache_done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wb_beat cyc %0d got v/data/rdy/rv/done=%h exp=%h", cyc, got, exp);
            end
            if (bus.mem_wdata_ready) k++;
            tick();
            cyc++;
        end
        checks++;
        if (k != WLEN) begin
            errors++;
            $display("FAIL wb_beat_count got=%0d exp=%0d", k, WLEN);
        end
        bus.cache_wdata_valid = 1'b0;
        bus.mem_wdata_ready   = 1'b0;
        bus.mem_rdata_valid   = 1'b0;
        #1;
        checks++;
        if ({bus.cache_done, bus.cache_req_ready, bus.cache_rdata_valid} !== 3'b100) begin
            errors++;
            $display("FAIL wb_done got done/rdy/rv=%b%b%b exp=100",
                     bus.cache_done, bus.cache_req_ready, bus.cache_rdata_valid);
        end
        tick();
        checks++;
        if ({bus.cache_done, bus.cache_req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL wb_idle got done/rdy=%b%b exp=01", bus.cache_done, bus.cache_req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.cache_req_ready, bus.mem_cmd_valid, bus.cache_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got rdy/cmd/done=%b%b%b exp=100",
                     bus.cache_req_ready, bus.mem_cmd_valid, bus.cache_done);
        end
    endtask

    task automatic test_refill_basic();
        int d0 = done_cnt;
        start_request(1'b0, 32'h40, 1'b0);
        cmd_phase(1'b0, 32'h40, 0);
        refill_data(32'hA0, 0);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL refill_basic_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_refill_cwf();
`ifdef CRITICAL_WORD_FIRST_EN
        logic [AW-1:0] exp_addr = 32'h4C;
        int            s        = 3;
`else
        logic [AW-1:0] exp_addr = 32'h40;
        int            s        = 0;
`endif
        start_request(1'b0, 32'h4C, 1'b0);
        cmd_phase(1'b0, exp_addr, 0);
        refill_data(32'hB0, s);
    endtask

    task automatic test_writeback();
        int d0 = done_cnt;
        start_request(1'b1, 32'h80, 1'b0);
        cmd_phase(1'b1, 32'h80, 3);
        wb_data(32'h10, 1'b1);
        tick();
        tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL wb_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_spurious_idle();
        for (int i = 0; i < 3; i++) begin
            bus.mem_rdata_valid   = 1'b1;
            bus.mem_rdata         = 32'h5555_0000 + 32'(i);
            bus.cache_wdata_valid = 1'b1;
            bus.mem_wdata_ready   = 1'b1;
            #1;
            checks++;
            if ({bus.cache_rdata_valid, bus.cache_req_ready, bus.mem_cmd_valid,
                 bus.cache_wdata_ready, bus.mem_wdata_valid} !== 5'b01000) begin
                errors++;
                $display("FAIL spurious_idle cyc %0d got rv/rdy/cmd/wrdy/wv=%b%b%b%b%b exp=01000", i,
                         bus.cache_rdata_valid, bus.cache_req_ready, bus.mem_cmd_valid,
                         bus.cache_wdata_ready, bus.mem_wdata_valid);
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.cache_rdata_valid !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle_after got=%b exp=0", bus.cache_rdata_valid);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        start_request(1'b0, 32'h60, 1'b1);
        // Write-back request waits, held valid, from the cycle after the refill handshake.
        bus.cache_req_write = 1'b1;
        bus.cache_req_addr  = 32'h9C;
        cmd_phase(1'b0, 32'h60, 0);
        refill_data(32'hC0, 0);
        tick();
        bus.cache_req_valid = 1'b0;
        cmd_phase(1'b1, 32'h80, 0);
        wb_data(32'h20, 1'b0);
        tick();
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_refill();
        int d0 = done_cnt;
        start_request(1'b0, 32'h40, 1'b0);
        cmd_phase(1'b0, 32'h40, 0);
        for (int j = 0; j < 4; j++) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = 32'hE0 + 32'(j);
            tick();
        end
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            checks++;
            if (all_outs() !== '0) begin
                errors++;
                $display("FAIL reset_mid_outputs cyc %0d got=%h exp=0", r, all_outs());
            end
        end
        rst = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        #1;
        checks++;
        if ({bus.cache_req_ready, bus.cache_rdata_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_release got rdy/rv=%b%b exp=10",
                     bus.cache_req_ready, bus.cache_rdata_valid);
        end
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if ((done_cnt - d0) != 0 || bus.mem_cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got done=%0d cmd=%b exp done=0 cmd=0",
                     done_cnt - d0, bus.mem_cmd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_refill_basic();
        test_refill_cwf();
        test_writeback();
        test_spurious_idle();
        test_back_to_back();
        test_reset_mid_refill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
